// File: rtl/imem_loader.sv
// imem_loader: boot-time instruction-memory writer.
// Receives a byte stream (4-byte little-endian word count N, then N
// little-endian words), writes the words to consecutive instruction-memory
// addresses starting at 0, and keeps the core in reset until a load completes.
// Optional feature macro: OPCODE_CHECK_EN. When defined, each word's opcode is
// screened against the set the decoder supports, and an unsupported opcode
// aborts the load.
//
// Byte handshake: a byte moves on a rising clock edge where
// rx_valid && rx_ready. rx_ready is a decode of the registered state and is
// high only while collecting header or data bytes. rx_valid may drop at any
// time; the loader simply waits.
module imem_loader #(
   parameter int ADDR_W = 9
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              rx_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              cpu_hold,
   output logic              done,
   output logic              error,
   output logic [1:0]        err_code,
   output logic [ADDR_W:0]   word_count,
   output logic [2:0]        dbg_state
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_HDR   = 3'd1;
   localparam logic [2:0] S_DATA  = 3'd2;
   localparam logic [2:0] S_WRITE = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;
   localparam logic [2:0] S_ERR   = 3'd5;

   localparam logic [31:0]       MAX_WORDS = 32'd1 << ADDR_W;
   localparam logic [ADDR_W:0]   CNT_ONE   = {{ADDR_W{1'b0}}, 1'b1};
   localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

   logic [2:0]        state_q, state_d;
   logic [1:0]        byte_cnt_q, byte_cnt_d;
   logic [31:0]       shift_q, shift_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [1:0]        err_code_q, err_code_d;
   logic [ADDR_W:0]   word_count_q, word_count_d;

   logic [31:0] asm_word;
   logic        xfer;
   logic        last_word;
   logic        opcode_ok;

   // The incoming byte lands in the top lane, so after four bytes the
   // first-received byte sits in bits [7:0] (little-endian assembly).
   assign asm_word  = {rx_data, shift_q[31:8]};
   assign xfer      = rx_valid && rx_ready;
   assign last_word = ({1'b0, addr_q} == (word_count_q - CNT_ONE));

`ifdef OPCODE_CHECK_EN
   // Accept only the opcodes the main decoder implements.
   always_comb begin
      case (wdata_q[6:0])
         7'b0110011, 7'b0000011, 7'b0100011, 7'b1100011,
         7'b0010011, 7'b1101111, 7'b1100111: opcode_ok = 1'b1;
         default:                            opcode_ok = 1'b0;
      endcase
   end
`else
   assign opcode_ok = 1'b1;
`endif

   // Next-state and datapath update for the load sequence.
   always_comb begin
      state_d      = state_q;
      byte_cnt_d   = byte_cnt_q;
      shift_d      = shift_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      err_code_d   = err_code_q;
      word_count_d = word_count_q;
      case (state_q)
         S_IDLE, S_DONE, S_ERR: begin
            if (start) begin
               state_d    = S_HDR;
               byte_cnt_d = 2'd0;
               addr_d     = '0;
               err_code_d = 2'b00;
            end
         end
         S_HDR: begin
            if (xfer) begin
               shift_d    = asm_word;
               byte_cnt_d = byte_cnt_q + 2'd1;
               if (byte_cnt_q == 2'd3) begin
                  // Full 32-bit compare: any count above capacity aborts.
                  if (asm_word > MAX_WORDS) begin
                     state_d    = S_ERR;
                     err_code_d = 2'b01;
                  end else begin
                     word_count_d = asm_word[ADDR_W:0];
                     state_d      = (asm_word == 32'd0) ? S_DONE : S_DATA;
                  end
               end
            end
         end
         S_DATA: begin
            if (xfer) begin
               shift_d    = asm_word;
               byte_cnt_d = byte_cnt_q + 2'd1;
               if (byte_cnt_q == 2'd3) begin
                  wdata_d = asm_word;
                  state_d = S_WRITE;
               end
            end
         end
         S_WRITE: begin
            byte_cnt_d = 2'd0;
            if (!opcode_ok) begin
               // imem_addr stays on the offending word for diagnosis.
               state_d    = S_ERR;
               err_code_d = 2'b10;
            end else if (last_word) begin
               state_d = S_DONE;
            end else begin
               addr_d  = addr_q + ADDR_ONE;
               state_d = S_DATA;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers; reset returns everything to idle at once.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= S_IDLE;
         byte_cnt_q   <= 2'd0;
         shift_q      <= 32'd0;
         addr_q       <= '0;
         wdata_q      <= 32'd0;
         err_code_q   <= 2'b00;
         word_count_q <= '0;
      end else begin
         state_q      <= state_d;
         byte_cnt_q   <= byte_cnt_d;
         shift_q      <= shift_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         err_code_q   <= err_code_d;
         word_count_q <= word_count_d;
      end
   end

   assign rx_ready   = (state_q == S_HDR) || (state_q == S_DATA);
   assign imem_we    = (state_q == S_WRITE) && opcode_ok;
   assign imem_addr  = addr_q;
   assign imem_wdata = wdata_q;
   assign cpu_hold   = (state_q != S_DONE);
   assign done       = (state_q == S_DONE);
   assign error      = (state_q == S_ERR);
   assign err_code   = err_code_q;
   assign word_count = word_count_q;
   assign dbg_state  = state_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed bench for imem_loader with an expected-write
// queue, a per-cycle compare process and literal timing expectations.
module tb_imem_loader;

   localparam int ADDR_W = 9;
`ifdef OPCODE_CHECK_EN
   localparam bit CHECK_EN = 1'b1;
`else
   localparam bit CHECK_EN = 1'b0;
`endif

   logic              clk;
   logic              reset;
   logic              start;
   logic [7:0]        rx_data;
   logic              rx_valid;
   logic              rx_ready;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_wdata;
   logic              cpu_hold;
   logic              done;
   logic              error;
   logic [1:0]        err_code;
   logic [ADDR_W:0]   word_count;
   logic [2:0]        dbg_state;

   imem_loader #(.ADDR_W(ADDR_W)) dut (
      .clk(clk), .reset(reset), .start(start),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
      .cpu_hold(cpu_hold), .done(done), .error(error), .err_code(err_code),
      .word_count(word_count), .dbg_state(dbg_state)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- scoreboard ----------------
   int n_checks = 0;
   int n_fail   = 0;
   logic [ADDR_W+31:0] exp_q[$];
   logic [31:0]        wbuf [0:511];
   logic               exp_done;
   logic               exp_err;
   logic [1:0]         exp_code;
   logic [ADDR_W-1:0]  exp_addr;
   logic [ADDR_W:0]    exp_wc;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   function automatic bit legal_op(input logic [6:0] op);
      logic [6:0] ops [7];
      ops = '{7'h33, 7'h03, 7'h23, 7'h63, 7'h13, 7'h6F, 7'h67};
      foreach (ops[i]) if (ops[i] == op) return 1'b1;
      return 1'b0;
   endfunction

   // Model of one load: which writes must appear and how the load ends.
   task automatic model_expect(input logic [31:0] n);
      exp_done = 1'b0; exp_err = 1'b0; exp_code = 2'b00; exp_addr = '0;
      if (n > 32'd512) begin
         exp_err = 1'b1; exp_code = 2'b01;
      end else begin
         exp_wc   = n[ADDR_W:0];
         exp_done = 1'b1;
         for (int i = 0; i < int'(n); i++) begin
            exp_addr = ADDR_W'(i);
            if (CHECK_EN && !legal_op(wbuf[i][6:0])) begin
               exp_done = 1'b0; exp_err = 1'b1; exp_code = 2'b10;
               break;
            end
            exp_q.push_back({ADDR_W'(i), wbuf[i]});
         end
      end
   endtask

   // Every cycle: each write must be the next expected one.
   always @(negedge clk) begin : cmp
      logic [ADDR_W+31:0] e;
      if (!reset) begin
         chk("hold_vs_done", cpu_hold, !done);
         if (imem_we) begin
            chk("ready_low_on_write", rx_ready, 1'b0);
            chk("write_expected", exp_q.size() > 0, 1'b1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               chk("write_addr", imem_addr, e[ADDR_W+31:32]);
               chk("write_data", imem_wdata, e[31:0]);
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic send_byte(input logic [7:0] b, input int max_gap);
      int gap;
      bit got;
      gap = (max_gap > 0) ? $urandom_range(max_gap, 0) : 0;
      got = 1'b0;
      rx_valid = 1'b0;
      repeat (gap) @(negedge clk);
      rx_valid = 1'b1;
      rx_data  = b;
      for (int t = 0; t < 50; t++) begin
         if (rx_ready) begin
            @(negedge clk);
            got = 1'b1;
            break;
         end
         @(negedge clk);
      end
      rx_valid = 1'b0;
      chk("byte_accepted", got, 1'b1);
   endtask

   task automatic send_word(input logic [31:0] w, input int max_gap);
      for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], max_gap);
   endtask

   task automatic send_load(input logic [31:0] n, input int nw, input int max_gap);
      send_word(n, max_gap);
      for (int i = 0; i < nw; i++) send_word(wbuf[i], max_gap);
   endtask

   task automatic pulse_start();
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
   endtask

   task automatic wait_end();
      for (int t = 0; t < 200; t++) begin
         if (done || error) break;
         @(negedge clk);
      end
      chk("load_finished", done || error, 1'b1);
   endtask

   task automatic check_final(input string tag);
      chk({tag, "_done"}, done, exp_done);
      chk({tag, "_error"}, error, exp_err);
      chk({tag, "_err_code"}, err_code, exp_code);
      chk({tag, "_cpu_hold"}, cpu_hold, !exp_done);
      chk({tag, "_rx_ready"}, rx_ready, 1'b0);
      chk({tag, "_writes_left"}, exp_q.size(), 0);
      if (exp_code != 2'b01) begin
         chk({tag, "_imem_addr"}, imem_addr, exp_addr);
         chk({tag, "_word_count"}, word_count, exp_wc);
      end
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_rx_ready"}, rx_ready, 1'b0);
      chk({tag, "_imem_we"}, imem_we, 1'b0);
      chk({tag, "_imem_addr"}, imem_addr, 0);
      chk({tag, "_imem_wdata"}, imem_wdata, 0);
      chk({tag, "_cpu_hold"}, cpu_hold, 1'b1);
      chk({tag, "_done"}, done, 1'b0);
      chk({tag, "_error"}, error, 1'b0);
      chk({tag, "_err_code"}, err_code, 2'b00);
      chk({tag, "_word_count"}, word_count, 0);
   endtask

   task automatic fill_legal(input int n);
      for (int i = 0; i < n; i++) wbuf[i] = ($urandom() & 32'hFFFF_FF80) | 32'h13;
   endtask

   // ---------------- main sequence ----------------
   int we_k0, we_k1, done_k, n_we;
   logic [31:0] ovf_hdr [3];

   initial begin
      reset = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (10) @(negedge clk);
      check_reset_vals("idle");

      // Two-word load, back-to-back bytes, with cycle-exact timing.
      wbuf[0] = 32'h0050_0093;
      wbuf[1] = 32'h0020_8133;
      model_expect(2);
      we_k0 = -1; we_k1 = -1; done_k = -1; n_we = 0;
      pulse_start();
      fork
         send_load(2, 2, 0);
         begin
            for (int k = 1; k <= 20; k++) begin
               if (imem_we) begin
                  if (n_we == 0) we_k0 = k; else we_k1 = k;
                  n_we++;
               end
               if (done && done_k < 0) done_k = k;
               @(negedge clk);
            end
         end
      join
      chk("lat_write_count", n_we, 2);
      chk("lat_first_write_cycle", we_k0, 9);
      chk("lat_second_write_cycle", we_k1, 14);
      chk("lat_done_cycle", done_k, 15);
      chk("lat_word_count", word_count, 2);
      chk("lat_last_addr", imem_addr, 1);
      check_final("two_word");

      // Empty load: done right after the header, no writes.
      model_expect(0);
      pulse_start();
      chk("restart_clears_done", done, 1'b0);
      chk("restart_holds_cpu", cpu_hold, 1'b1);
      send_word(32'd0, 0);
      chk("empty_done_next_cycle", done, 1'b1);
      check_final("empty");

      // Length overflow 513, then a good gapped load.
      model_expect(513);
      pulse_start();
      send_word(32'd513, 0);
      chk("ovf_error_next_cycle", error, 1'b1);
      check_final("ovf513");
      fill_legal(3);
      model_expect(3);
      pulse_start();
      chk("restart_clears_error", error, 1'b0);
      chk("restart_clears_code", err_code, 2'b00);
      send_load(3, 3, 2);
      wait_end();
      check_final("after_ovf");

      // Overflow by high bits only.
      ovf_hdr = '{32'h0000_0400, 32'h0100_0000, 32'h8000_0000};
      foreach (ovf_hdr[i]) begin
         model_expect(ovf_hdr[i]);
         pulse_start();
         send_word(ovf_hdr[i], 1);
         check_final("ovf_high");
      end

      // Exactly full capacity.
      fill_legal(512);
      model_expect(512);
      pulse_start();
      send_load(512, 512, 0);
      wait_end();
      chk("full_word_count", word_count, 10'h200);
      chk("full_last_addr", imem_addr, 9'h1FF);
      check_final("full");

      // Second word is LUI, outside the decoder's set.
      wbuf[0] = 32'h0050_0093;
      wbuf[1] = 32'h0000_0037;
      model_expect(2);
      pulse_start();
      send_load(2, 2, 1);
      wait_end();
      check_final("lui");

      // Reset in the middle of the third word, gapped stream.
      fill_legal(4);
      exp_q.delete();
      exp_q.push_back({ADDR_W'(0), wbuf[0]});
      exp_q.push_back({ADDR_W'(1), wbuf[1]});
      pulse_start();
      send_word(32'd4, 3);
      send_word(wbuf[0], 3);
      send_word(wbuf[1], 3);
      send_byte(wbuf[2][7:0], 3);
      send_byte(wbuf[2][15:8], 3);
      reset = 1'b1;
      #1;
      check_reset_vals("async_reset");
      chk("writes_before_reset", exp_q.size(), 0);
      @(negedge clk) reset = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_vals("post_reset");
      model_expect(4);
      pulse_start();
      send_load(4, 4, 3);
      wait_end();
      check_final("reload");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Global watchdog so the run always terminates.
   initial begin
      #2000000;
      n_fail++;
      $display("FAIL watchdog: got timeout, expected end of sequence");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
